// File: rtl/uart_word_loader.sv
// Purpose : parses host frames (START, N, 4*N data bytes) from the UART RX FIFO into 32-bit LE memory words, replies checksum/NAK.
// Latency : 1 cycle from the 4th byte of a word being popped to mem_we; ACK/NAK pushed the cycle TX FIFO has room.
// Backpressure: stalls on Rx_empty (no pop); holds ACK/NAK while Tx_full; never pops RX outside IDLE/COUNT/DATA.
//
// Ports:
//   clk, rst_n          - clock (rising edge), synchronous active-low reset
//   r_data, Rx_empty    - RX FIFO head byte and empty flag
//   rd_uart             - RX FIFO pop (combinational; head consumed at this edge)
//   w_data, wr_uart     - TX FIFO byte and one-cycle push
//   Tx_full             - TX FIFO full
//   mem_we/addr/wdata   - word write port to instruction/data memory
//   busy, done          - frame in progress; one-cycle success pulse
module uart_word_loader #(
    parameter int                    ADDR_WIDTH = 10,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter logic [7:0]            START_BYTE = 8'hA5,
    parameter logic [7:0]            NAK_BYTE   = 8'hEE
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            r_data,
    input  logic                  Rx_empty,
    output logic                  rd_uart,
    output logic [7:0]            w_data,
    output logic                  wr_uart,
    input  logic                  Tx_full,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNT,
        S_DATA,
        S_WRITE,
        S_ACK,
        S_NAK,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  w_rd;
    logic                  w_wr;
    logic                  w_we;
    logic [7:0]            r_words_left;
    logic [1:0]            r_byte_idx;
    logic [7:0]            r_checksum;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]           r_wdata;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and outputs
    always_comb begin
        w_next = r_state;
        w_rd   = 1'b0;
        w_wr   = 1'b0;
        w_we   = 1'b0;
        w_data = 8'h00;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_rd = !Rx_empty;
                if (w_rd && (r_data == START_BYTE)) begin
                    w_next = S_COUNT;
                end
            end
            S_COUNT: begin
                busy = 1'b1;
                w_rd = !Rx_empty;
                if (w_rd) begin
                    w_next = (r_data == 8'h00) ? S_NAK : S_DATA;
                end
            end
            S_DATA: begin
                busy = 1'b1;
                w_rd = !Rx_empty;
                if (w_rd && (r_byte_idx == 2'd3)) begin
                    w_next = S_WRITE;
                end
            end
            S_WRITE: begin
                busy   = 1'b1;
                w_we   = 1'b1;
                w_next = (r_words_left == 8'd1) ? S_ACK : S_DATA;
            end
            S_ACK: begin
                busy   = 1'b1;
                w_data = r_checksum;
                if (!Tx_full) begin
                    w_wr   = 1'b1;
                    w_next = S_DONE;
                end
            end
            S_NAK: begin
                busy   = 1'b1;
                w_data = NAK_BYTE;
                if (!Tx_full) begin
                    w_wr   = 1'b1;
                    w_next = S_IDLE;
                end
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Strobes are masked while reset is held so nothing leaks in the reset cycle.
    assign rd_uart   = w_rd & rst_n;
    assign wr_uart   = w_wr & rst_n;
    assign mem_we    = w_we & rst_n;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;

    // Datapath: word assembly, checksum, address and word counting
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_words_left <= 8'd0;
            r_byte_idx   <= 2'd0;
            r_checksum   <= 8'd0;
            r_addr       <= BASE_ADDR;
            r_wdata      <= 32'd0;
        end else begin
            case (r_state)
                S_COUNT: begin
                    if (w_rd && (r_data != 8'h00)) begin
                        r_words_left <= r_data;
                        r_addr       <= BASE_ADDR;
                        r_checksum   <= 8'd0;
                        r_byte_idx   <= 2'd0;
                    end
                end
                S_DATA: begin
                    if (w_rd) begin
                        r_wdata[{r_byte_idx, 3'b000} +: 8] <= r_data;
                        r_checksum <= r_checksum ^ r_data;
                        r_byte_idx <= r_byte_idx + 2'd1;
                    end
                end
                S_WRITE: begin
                    // Address wraps naturally at 2^ADDR_WIDTH.
                    r_addr       <= r_addr + 1'b1;
                    r_words_left <= r_words_left - 8'd1;
                    r_byte_idx   <= 2'd0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_word_loader.sv
// Purpose : randomized self-checking bench for uart_word_loader against a frame-level reference model.
// Latency : n/a (bench).
// Backpressure: bench emulates RX FIFO (queue + random starvation) and TX FIFO full (hold / random).
module tb_uart_word_loader;

    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [7:0]    r_data;
    logic          Rx_empty;
    logic          rd_uart;
    logic [7:0]    w_data;
    logic          wr_uart;
    logic          Tx_full;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    uart_word_loader #(
        .ADDR_WIDTH (AW),
        .BASE_ADDR  ('0),
        .START_BYTE (8'hA5),
        .NAK_BYTE   (8'hEE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .r_data    (r_data),
        .Rx_empty  (Rx_empty),
        .rd_uart   (rd_uart),
        .w_data    (w_data),
        .wr_uart   (wr_uart),
        .Tx_full   (Tx_full),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done)
    );

    // RX FIFO emulation and stimulus knobs
    logic [7:0]  rx_q[$];
    int          gap_pct;
    bit          toggle_mode;
    bit          toggle_ph;
    int          tx_hold;
    bit          tx_rand;

    // Observations
    logic [31:0] obs_addr[$];
    logic [31:0] obs_data[$];
    logic [7:0]  obs_tx[$];
    int          done_cnt;
    int          cyc;
    int          first_tx_cyc;
    int          viol_rd;
    int          viol_wr;

    // Stimulus buffers for run_frame
    logic [7:0]  g_garb[$];
    logic [7:0]  g_data[$];

    int          errors;
    int          checks;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_obs();
        obs_addr.delete();
        obs_data.delete();
        obs_tx.delete();
        done_cnt     = 0;
        first_tx_cyc = -1;
    endtask

    // One clock: drive inputs at the falling edge, sample what the DUT will act on at the next rising edge.
    task automatic step();
        bit starve;
        @(negedge clk);
        cyc++;
        starve = (rx_q.size() == 0);
        if (toggle_mode) begin
            toggle_ph = !toggle_ph;
            if (toggle_ph) starve = 1'b1;
        end else if ($urandom_range(99) < gap_pct) begin
            starve = 1'b1;
        end
        Rx_empty = starve;
        r_data   = starve ? 8'($urandom) : rx_q[0];
        Tx_full  = (tx_hold > 0) || (tx_rand && ($urandom_range(3) == 0));
        if (tx_hold > 0) tx_hold--;
        #1;
        if (rd_uart) begin
            if (Rx_empty) viol_rd++;
            else void'(rx_q.pop_front());
        end
        if (mem_we) begin
            obs_addr.push_back(32'(mem_addr));
            obs_data.push_back(mem_wdata);
        end
        if (wr_uart) begin
            obs_tx.push_back(w_data);
            if (Tx_full) viol_wr++;
            if (first_tx_cyc < 0) first_tx_cyc = cyc;
        end
        if (done) done_cnt++;
    endtask

    // Pushes garbage + frame, runs until the reply is out, and compares against the frame-level model.
    task automatic run_frame(input int n, input string tag);
        logic [31:0] exp_word[$];
        logic [31:0] exp_addr[$];
        logic [7:0]  exp_tx;
        int          budget;
        int          nw;
        clear_obs();
        foreach (g_garb[i]) rx_q.push_back(g_garb[i]);
        rx_q.push_back(8'hA5);
        rx_q.push_back(8'(n));
        foreach (g_data[i]) rx_q.push_back(g_data[i]);

        exp_tx = (n == 0) ? 8'hEE : 8'h00;
        for (int w = 0; w < n; w++) begin
            exp_word.push_back({g_data[4*w+3], g_data[4*w+2], g_data[4*w+1], g_data[4*w]});
            exp_addr.push_back(32'(w % (1 << AW)));
            for (int b = 0; b < 4; b++) exp_tx = exp_tx ^ g_data[4*w+b];
        end

        budget = 0;
        do begin
            step();
            budget++;
        end while (!(rx_q.size() == 0 && obs_tx.size() > 0 && !busy) && budget < 4000);
        if (budget >= 4000) chk({tag, "_timeout"}, 32'd1, 32'd0);
        repeat (2) step();

        chk({tag, "_nwrites"}, 32'(obs_addr.size()), 32'(n));
        nw = (obs_addr.size() < n) ? obs_addr.size() : n;
        for (int w = 0; w < nw; w++) begin
            chk($sformatf("%s_addr%0d", tag, w), obs_addr[w], exp_addr[w]);
            chk($sformatf("%s_data%0d", tag, w), obs_data[w], exp_word[w]);
        end
        chk({tag, "_ntx"}, 32'(obs_tx.size()), 32'd1);
        if (obs_tx.size() > 0) chk({tag, "_txbyte"}, 32'(obs_tx[0]), 32'(exp_tx));
        chk({tag, "_done"}, 32'(done_cnt), (n == 0) ? 32'd0 : 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic fill_data(input int n);
        g_data.delete();
        for (int i = 0; i < 4*n; i++) g_data.push_back(8'($urandom));
    endtask

    initial begin
        int c0;
        int n;
        errors = 0; checks = 0; cyc = 0;
        viol_rd = 0; viol_wr = 0;
        gap_pct = 0; toggle_mode = 0; toggle_ph = 0; tx_hold = 0; tx_rand = 0;
        rst_n = 1'b0; Rx_empty = 1'b1; r_data = 8'h00; Tx_full = 1'b0;
        clear_obs();

        // Reset values
        repeat (3) step();
        chk("rst_rd_uart",  32'(rd_uart),  32'd0);
        chk("rst_wr_uart",  32'(wr_uart),  32'd0);
        chk("rst_mem_we",   32'(mem_we),   32'd0);
        chk("rst_busy",     32'(busy),     32'd0);
        chk("rst_done",     32'(done),     32'd0);
        chk("rst_w_data",   32'(w_data),   32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_wdata",    mem_wdata,     32'd0);
        rst_n = 1'b1;
        step();

        // Single word, back-to-back bytes
        g_garb.delete();
        g_data = '{8'h78, 8'h56, 8'h34, 8'h12};
        run_frame(1, "one");

        // Garbage prefix then two words
        g_garb = '{8'h00, 8'hFF, 8'h3C};
        g_data = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        run_frame(2, "two");

        // Zero count is rejected
        g_garb.delete();
        g_data.delete();
        run_frame(0, "nak");

        // TX FIFO held full for a while at the end of a valid frame
        g_data = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        tx_hold = 30;
        c0 = cyc;
        run_frame(1, "txfull");
        chk("txfull_wait", 32'(first_tx_cyc - c0 >= 31), 32'd1);

        // RX starving every other cycle: same result as back-to-back
        toggle_mode = 1;
        g_data = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        run_frame(2, "toggle");
        toggle_mode = 0;

        // Randomized frames with random gaps, garbage and TX backpressure
        tx_rand = 1;
        for (int f = 0; f < 10; f++) begin
            gap_pct = $urandom_range(50);
            g_garb.delete();
            for (int i = 0; i < $urandom_range(3); i++) g_garb.push_back(8'($urandom_range(8'hA4)));
            n = ($urandom_range(5) == 0) ? 0 : $urandom_range(1, 6);
            fill_data(n);
            run_frame(n, $sformatf("rnd%0d", f));
        end

        // Word count larger than memory: address wraps
        gap_pct = 10;
        g_garb.delete();
        fill_data(20);
        run_frame(20, "wrap");
        gap_pct = 0;
        tx_rand = 0;

        // Reset after 6 of 8 data bytes
        clear_obs();
        g_data = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        rx_q.push_back(8'hA5);
        rx_q.push_back(8'h02);
        foreach (g_data[i]) rx_q.push_back(g_data[i]);
        begin
            int b;
            b = 0;
            while (rx_q.size() != 0 && b < 200) begin
                step();
                b++;
            end
            if (b >= 200) chk("midrst_timeout", 32'd1, 32'd0);
        end
        repeat (2) step();
        rst_n = 1'b0;
        step();
        chk("midrst_addr_in_rst", 32'(mem_addr), 32'd0);
        chk("midrst_busy_in_rst", 32'(busy), 32'd0);
        rst_n = 1'b1;
        repeat (10) step();
        chk("midrst_nwrites", 32'(obs_addr.size()), 32'd1);
        if (obs_addr.size() > 0) begin
            chk("midrst_addr0", obs_addr[0], 32'd0);
            chk("midrst_data0", obs_data[0], 32'h44332211);
        end
        chk("midrst_ntx",  32'(obs_tx.size()), 32'd0);
        chk("midrst_done", 32'(done_cnt), 32'd0);
        chk("midrst_addr", 32'(mem_addr), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);

        // Protocol invariants over the whole run
        chk("pop_while_empty", 32'(viol_rd), 32'd0);
        chk("push_while_full", 32'(viol_wr), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
